pipeline_stage_ctrl: RTL and testbench
======================================

// Module: pipeline_stage_ctrl
// PURPOSE
//  Consumer of the hazard unit's stall/flush/redirect requests. Holds per-stage
//  valid bits and destination/load/store sideband for IF/ID/EX/MEM/WB. Applies
//  stalls, bubbles and flushes each cycle. Drives PC source/enable and feeds
//  stage-invalid/rd/load info back to the hazard unit.
// PARAMETERS
//  XLEN       32  PC / target width
//  MAX_STALL  15  consecutive-stall limit before stall_timeout sets (>=1)
//  CNT_W      4   stall counter width; must satisfy 2**CNT_W-1 >= MAX_STALL
// PORTS
//  clk              in   1     clock, all state updates on posedge
//  reset            in   1     synchronous, active-high
//  stop_IF          in   1     hold PC; ID receives bubble unless stop_ID
//  stop_ID          in   1     hold IF/ID register; EX receives bubble
//  set_invalid_IF/ID/EX/MEM  in 1 each  kill the instruction in that stage
//  took_branch      in   1     redirect to branch_target
//  any_excep        in   1     redirect to trap_vector
//  ret              in   1     redirect to mepc
//  branch_target    in   XLEN
//  trap_vector      in   XLEN
//  mepc             in   XLEN
//  ID_rd            in   5     rd of instruction in ID
//  ID_is_load       in   1
//  ID_is_store      in   1
//  EX_invalid, MEM_invalid, WB_invalid  out 1 each  = ~valid of that stage
//  EX_rd, MEM_rd, WB_rd                 out 5 each
//  is_load_EX, is_store_EX, is_load_MEM out 1 each
//  pc_write_en      out  1     PC register load enable
//  pc_sel           out  2     0 seq, 1 branch, 2 trap, 3 mret
//  pc_next_redirect out  XLEN  selected redirect target (valid when pc_sel!=0)
//  IF_ID_en, ID_EX_en  out 1   datapath pipeline-register enables
//  retire           out  1     WB holds a valid instruction this cycle
//  redirect_busy    out  1     FSM is in REDIRECT
//  stall_timeout    out  1     sticky; consecutive stalls reached MAX_STALL
// BEHAVIOUR
//  Reset: all valid bits 0, all sideband 0 (every *_invalid out = 1), pc_sel 0,
//   counter 0, stall_timeout 0, FSM RUN. vIF becomes 1 on the first cycle after reset.
//  Per posedge (not reset), flush beats stall:
//   vWB <= vMEM & ~set_invalid_MEM;  vMEM <= vEX & ~set_invalid_EX
//   vEX <= (stop_ID & ~took_branch) ? 0 : vID & ~set_invalid_ID
//   vID <= took_branch ? 0 : stop_ID ? vID & ~set_invalid_ID
//          : stop_IF ? 0 : vIF & ~set_invalid_IF
//   vIF <= ~set_invalid_IF
//  Sideband (rd, is_load, is_store) moves with its valid bit; forced to 0 when
//   the destination stage receives a bubble or kill.
//  Comb: pc_sel = took_branch?1 : any_excep?2 : ret?3 : 0 (branch > excep > ret).
//   pc_write_en = ~stop_IF | (pc_sel!=0). IF_ID_en = ~stop_ID | took_branch.
//   ID_EX_en = 1. retire = vWB.
//  FSM RUN/STALL/REDIRECT:
//   RUN->REDIRECT when pc_sel!=0; RUN->STALL when stop_IF|stop_ID.
//   STALL->REDIRECT when pc_sel!=0; STALL->RUN when stalls drop.
//   REDIRECT lasts exactly one cycle, then RUN or STALL per the current inputs.
//   A new redirect in REDIRECT re-enters REDIRECT; stop inputs there are still obeyed.
//  Stall counter: +1 each cycle stop_IF|stop_ID, saturates at MAX_STALL;
//   clears on the first non-stall cycle or on a redirect.
//   stall_timeout sets when count==MAX_STALL; clears only on reset.
//  Reset mid-stall/redirect: full reset state next cycle; in-flight work dropped.
// STRUCTURE
//  Shared header pipeline_defs.vh: PC_SEL_{SEQ,BR,TRAP,MRET}, FSM state codes.
//  One sub-module, pipe_stage_reg: valid + {rd,is_load,is_store} register with
//   hold/bubble/kill inputs, instantiated for ID, EX, MEM and WB.
// TESTING
//  reset 3 cycles -> all *_invalid=1, pc_sel=0; cycle after release, vIF=1.
//  Load to x5 in EX, stop_IF=stop_ID=1 for 1 cycle -> EX_invalid=1 next cycle,
//   ID held, is_load_MEM=1, MEM_rd=5, pc_write_en=0 during the stall.
//  took_branch=1, branch_target=0x100 with stop_ID=1 -> pc_sel=1,
//   pc_write_en=1, IF_ID_en=1, ID/EX invalid next cycle, redirect_busy=1 1 cycle.
//  any_excep=1 and ret=1 together -> pc_sel=2, pc_next_redirect=trap_vector.
//  stop_ID held 15 cycles -> stall_timeout=1 at count 15, stays 1 after release.
//  reset asserted during REDIRECT -> next cycle FSM RUN, all valids 0.

Source files
------------

// File: rtl/pipeline_stage_ctrl_pkg.sv
// Shared types and constants for the pipeline stage controller.
// PC-source codes, FSM states, the per-stage sideband record and the redirect priority encoder.
package pipeline_stage_ctrl_pkg;

  localparam logic [1:0] PcSelSeq  = 2'd0;
  localparam logic [1:0] PcSelBr   = 2'd1;
  localparam logic [1:0] PcSelTrap = 2'd2;
  localparam logic [1:0] PcSelMret = 2'd3;

  typedef enum logic [1:0] {
    StRun,
    StStall,
    StRedirect
  } state_e;

  typedef struct packed {
    logic [4:0] rd;
    logic       is_load;
    logic       is_store;
  } side_t;

  localparam int unsigned SideW = $bits(side_t);

  // Branch outranks exception, which outranks mret.
  function automatic logic [1:0] pc_sel_f(logic br, logic excep, logic mret);
    if (br)         return PcSelBr;
    else if (excep) return PcSelTrap;
    else if (mret)  return PcSelMret;
    else            return PcSelSeq;
  endfunction

endpackage

// File: rtl/pipeline_stage_ctrl_pipe_stage_reg.sv
// One pipeline stage: valid bit plus sideband, with hold, bubble and kill controls.
// The sideband is zeroed whenever the stage does not hold a valid instruction.
module pipeline_stage_ctrl_pipe_stage_reg #(
  parameter int unsigned Width = 7
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             valid_i,
  input  logic [Width-1:0] data_i,
  input  logic             hold_i,
  input  logic             bubble_i,
  input  logic             kill_i,
  output logic             valid_o,
  output logic [Width-1:0] data_o
);

  logic             valid_d, valid_q;
  logic [Width-1:0] data_d, data_q;

  always_comb begin
    valid_d = valid_i;
    data_d  = valid_i ? data_i : '0;
    if (bubble_i) begin
      valid_d = 1'b0;
      data_d  = '0;
    end else if (hold_i) begin
      valid_d = valid_q & ~kill_i;
      data_d  = valid_d ? data_q : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipeline_stage_ctrl.sv
// Applies hazard-unit stall/flush/redirect requests to the IF..WB valid bits and sideband,
// selects the PC source and tracks run/stall/redirect state plus a sticky stall timeout.
module pipeline_stage_ctrl
  import pipeline_stage_ctrl_pkg::*;
#(
  parameter int unsigned Xlen     = 32,
  parameter int unsigned MaxStall = 15,
  parameter int unsigned CntW     = 4
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            stop_if_i,
  input  logic            stop_id_i,
  input  logic            set_invalid_if_i,
  input  logic            set_invalid_id_i,
  input  logic            set_invalid_ex_i,
  input  logic            set_invalid_mem_i,
  input  logic            took_branch_i,
  input  logic            any_excep_i,
  input  logic            ret_i,
  input  logic [Xlen-1:0] branch_target_i,
  input  logic [Xlen-1:0] trap_vector_i,
  input  logic [Xlen-1:0] mepc_i,
  input  logic [4:0]      id_rd_i,
  input  logic            id_is_load_i,
  input  logic            id_is_store_i,
  output logic            ex_invalid_o,
  output logic            mem_invalid_o,
  output logic            wb_invalid_o,
  output logic [4:0]      ex_rd_o,
  output logic [4:0]      mem_rd_o,
  output logic [4:0]      wb_rd_o,
  output logic            is_load_ex_o,
  output logic            is_store_ex_o,
  output logic            is_load_mem_o,
  output logic            pc_write_en_o,
  output logic [1:0]      pc_sel_o,
  output logic [Xlen-1:0] pc_next_redirect_o,
  output logic            if_id_en_o,
  output logic            id_ex_en_o,
  output logic            retire_o,
  output logic            redirect_busy_o,
  output logic            stall_timeout_o
);

  localparam logic [CntW-1:0] CntMax = CntW'(MaxStall);

  logic       valid_if_q;
  logic       valid_id, valid_ex, valid_mem, valid_wb;
  logic [0:0] id_data_unused;
  side_t      id_side, ex_side, mem_side, wb_side;
  logic       redirect, stalling;

  assign id_side  = '{rd: id_rd_i, is_load: id_is_load_i, is_store: id_is_store_i};
  assign pc_sel_o = pc_sel_f(took_branch_i, any_excep_i, ret_i);
  assign redirect = (pc_sel_o != PcSelSeq);
  assign stalling = stop_if_i | stop_id_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) valid_if_q <= 1'b0;
    else         valid_if_q <= ~set_invalid_if_i;
  end

  // A branch empties ID even when ID is being held.
  pipeline_stage_ctrl_pipe_stage_reg #(.Width(1)) u_id (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .valid_i  (valid_if_q & ~set_invalid_if_i),
    .data_i   (1'b0),
    .hold_i   (stop_id_i),
    .bubble_i (took_branch_i | (~stop_id_i & stop_if_i)),
    .kill_i   (set_invalid_id_i),
    .valid_o  (valid_id),
    .data_o   (id_data_unused)
  );

  pipeline_stage_ctrl_pipe_stage_reg #(.Width(SideW)) u_ex (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .valid_i  (valid_id & ~set_invalid_id_i),
    .data_i   (id_side),
    .hold_i   (1'b0),
    .bubble_i (stop_id_i & ~took_branch_i),
    .kill_i   (1'b0),
    .valid_o  (valid_ex),
    .data_o   (ex_side)
  );

  pipeline_stage_ctrl_pipe_stage_reg #(.Width(SideW)) u_mem (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .valid_i  (valid_ex & ~set_invalid_ex_i),
    .data_i   (ex_side),
    .hold_i   (1'b0),
    .bubble_i (1'b0),
    .kill_i   (1'b0),
    .valid_o  (valid_mem),
    .data_o   (mem_side)
  );

  pipeline_stage_ctrl_pipe_stage_reg #(.Width(SideW)) u_wb (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .valid_i  (valid_mem & ~set_invalid_mem_i),
    .data_i   (mem_side),
    .hold_i   (1'b0),
    .bubble_i (1'b0),
    .kill_i   (1'b0),
    .valid_o  (valid_wb),
    .data_o   (wb_side)
  );

  // FSM and stall counter
  state_e          state_d, state_q;
  logic [CntW-1:0] cnt_d, cnt_q;
  logic            timeout_d, timeout_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun, StStall, StRedirect: begin
        if (redirect)      state_d = StRedirect;
        else if (stalling) state_d = StStall;
        else               state_d = StRun;
      end
      default: state_d = StRun;
    endcase

    cnt_d = '0;
    if (!redirect && stalling) cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
    timeout_d = timeout_q | (cnt_d == CntMax);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= StRun;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    pc_next_redirect_o = '0;
    unique case (pc_sel_o)
      PcSelBr:   pc_next_redirect_o = branch_target_i;
      PcSelTrap: pc_next_redirect_o = trap_vector_i;
      PcSelMret: pc_next_redirect_o = mepc_i;
      default:   pc_next_redirect_o = '0;
    endcase
  end

  assign pc_write_en_o   = ~stop_if_i | redirect;
  assign if_id_en_o      = ~stop_id_i | took_branch_i;
  assign id_ex_en_o      = 1'b1;
  assign retire_o        = valid_wb;
  assign redirect_busy_o = (state_q == StRedirect);
  assign stall_timeout_o = timeout_q;

  assign ex_invalid_o  = ~valid_ex;
  assign mem_invalid_o = ~valid_mem;
  assign wb_invalid_o  = ~valid_wb;
  assign ex_rd_o       = ex_side.rd;
  assign mem_rd_o      = mem_side.rd;
  assign wb_rd_o       = wb_side.rd;
  assign is_load_ex_o  = ex_side.is_load;
  assign is_store_ex_o = ex_side.is_store;
  assign is_load_mem_o = mem_side.is_load;

endmodule

// File: tb/tb_pipeline_stage_ctrl.sv
// Directed bench for pipeline_stage_ctrl: reset, stall, branch, priority, timeout, reset-in-redirect.
module tb_pipeline_stage_ctrl;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        stop_if_i, stop_id_i;
  logic        set_invalid_if_i, set_invalid_id_i, set_invalid_ex_i, set_invalid_mem_i;
  logic        took_branch_i, any_excep_i, ret_i;
  logic [31:0] branch_target_i, trap_vector_i, mepc_i;
  logic [4:0]  id_rd_i;
  logic        id_is_load_i, id_is_store_i;
  logic        ex_invalid_o, mem_invalid_o, wb_invalid_o;
  logic [4:0]  ex_rd_o, mem_rd_o, wb_rd_o;
  logic        is_load_ex_o, is_store_ex_o, is_load_mem_o;
  logic        pc_write_en_o;
  logic [1:0]  pc_sel_o;
  logic [31:0] pc_next_redirect_o;
  logic        if_id_en_o, id_ex_en_o, retire_o, redirect_busy_o, stall_timeout_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  pipeline_stage_ctrl dut (
    .clk_i              (clk_i),
    .reset_i            (reset_i),
    .stop_if_i          (stop_if_i),
    .stop_id_i          (stop_id_i),
    .set_invalid_if_i   (set_invalid_if_i),
    .set_invalid_id_i   (set_invalid_id_i),
    .set_invalid_ex_i   (set_invalid_ex_i),
    .set_invalid_mem_i  (set_invalid_mem_i),
    .took_branch_i      (took_branch_i),
    .any_excep_i        (any_excep_i),
    .ret_i              (ret_i),
    .branch_target_i    (branch_target_i),
    .trap_vector_i      (trap_vector_i),
    .mepc_i             (mepc_i),
    .id_rd_i            (id_rd_i),
    .id_is_load_i       (id_is_load_i),
    .id_is_store_i      (id_is_store_i),
    .ex_invalid_o       (ex_invalid_o),
    .mem_invalid_o      (mem_invalid_o),
    .wb_invalid_o       (wb_invalid_o),
    .ex_rd_o            (ex_rd_o),
    .mem_rd_o           (mem_rd_o),
    .wb_rd_o            (wb_rd_o),
    .is_load_ex_o       (is_load_ex_o),
    .is_store_ex_o      (is_store_ex_o),
    .is_load_mem_o      (is_load_mem_o),
    .pc_write_en_o      (pc_write_en_o),
    .pc_sel_o           (pc_sel_o),
    .pc_next_redirect_o (pc_next_redirect_o),
    .if_id_en_o         (if_id_en_o),
    .id_ex_en_o         (id_ex_en_o),
    .retire_o           (retire_o),
    .redirect_busy_o    (redirect_busy_o),
    .stall_timeout_o    (stall_timeout_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle away from it.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  initial begin
    reset_i = 1'b1;
    {stop_if_i, stop_id_i} = '0;
    {set_invalid_if_i, set_invalid_id_i, set_invalid_ex_i, set_invalid_mem_i} = '0;
    {took_branch_i, any_excep_i, ret_i} = '0;
    branch_target_i = 32'h0; trap_vector_i = 32'h0; mepc_i = 32'h0;
    id_rd_i = 5'd0; id_is_load_i = 1'b0; id_is_store_i = 1'b0;

    // Reset state
    tick(3);
    check("rst_ex_inv",  ex_invalid_o, 1);
    check("rst_mem_inv", mem_invalid_o, 1);
    check("rst_wb_inv",  wb_invalid_o, 1);
    check("rst_pc_sel",  pc_sel_o, 0);
    check("rst_retire",  retire_o, 0);
    check("rst_timeout", stall_timeout_o, 0);
    check("rst_busy",    redirect_busy_o, 0);
    check("id_ex_en",    id_ex_en_o, 1);

    // IF valid at edge 1, ID at edge 2, EX at edge 3
    reset_i = 1'b0;
    tick(2);
    check("fill_ex_inv_e2", ex_invalid_o, 1);
    id_rd_i = 5'd5; id_is_load_i = 1'b1;
    tick();
    check("fill_ex_inv_e3", ex_invalid_o, 0);
    check("fill_ex_rd",     ex_rd_o, 5);
    check("fill_ex_load",   is_load_ex_o, 1);

    // One-cycle full stall with the load in EX
    stop_if_i = 1'b1; stop_id_i = 1'b1;
    id_rd_i = 5'd7; id_is_load_i = 1'b0;
    #1;
    check("stall_pc_we",    pc_write_en_o, 0);
    check("stall_ifid_en",  if_id_en_o, 0);
    tick();
    check("stall_ex_inv",   ex_invalid_o, 1);
    check("stall_ex_rd",    ex_rd_o, 0);
    check("stall_mem_rd",   mem_rd_o, 5);
    check("stall_mem_load", is_load_mem_o, 1);
    check("stall_busy",     redirect_busy_o, 0);
    stop_if_i = 1'b0; stop_id_i = 1'b0;
    tick();
    check("held_id_to_ex",  ex_invalid_o, 0);
    check("held_ex_rd",     ex_rd_o, 7);
    check("wb_rd",          wb_rd_o, 5);
    check("retire",         retire_o, 1);

    // Branch with ID stop and ID kill
    took_branch_i = 1'b1; branch_target_i = 32'h100;
    stop_id_i = 1'b1; stop_if_i = 1'b1; set_invalid_id_i = 1'b1;
    #1;
    check("br_pc_sel",   pc_sel_o, 1);
    check("br_pc_we",    pc_write_en_o, 1);
    check("br_ifid_en",  if_id_en_o, 1);
    check("br_target",   pc_next_redirect_o, 32'h100);
    tick();
    took_branch_i = 1'b0; stop_id_i = 1'b0; stop_if_i = 1'b0; set_invalid_id_i = 1'b0;
    check("br_ex_inv",   ex_invalid_o, 1);
    check("br_busy",     redirect_busy_o, 1);
    tick();
    check("br_busy_off", redirect_busy_o, 0);
    check("br_id_inv",   ex_invalid_o, 1);

    // Redirect priority
    any_excep_i = 1'b1; ret_i = 1'b1; trap_vector_i = 32'h200; mepc_i = 32'h300;
    #1;
    check("exc_pc_sel",  pc_sel_o, 2);
    check("exc_target",  pc_next_redirect_o, 32'h200);
    any_excep_i = 1'b0;
    #1;
    check("ret_pc_sel",  pc_sel_o, 3);
    check("ret_target",  pc_next_redirect_o, 32'h300);
    took_branch_i = 1'b1; any_excep_i = 1'b1;
    #1;
    check("prio_pc_sel", pc_sel_o, 1);
    took_branch_i = 1'b0; any_excep_i = 1'b0; ret_i = 1'b0;
    #1;
    check("seq_pc_sel",  pc_sel_o, 0);

    // Stall timeout at 15 consecutive stall cycles, sticky afterwards
    stop_id_i = 1'b1;
    tick(14);
    check("to_14",       stall_timeout_o, 0);
    tick();
    check("to_15",       stall_timeout_o, 1);
    tick(3);
    stop_id_i = 1'b0;
    tick(2);
    check("to_sticky",   stall_timeout_o, 1);

    // Kill in MEM and EX on the same edge
    id_rd_i = 5'd9; id_is_store_i = 1'b1;
    tick(3);
    check("pre_kill_mem", mem_invalid_o, 0);
    check("pre_kill_wb",  retire_o, 1);
    set_invalid_ex_i = 1'b1; set_invalid_mem_i = 1'b1;
    tick();
    set_invalid_ex_i = 1'b0; set_invalid_mem_i = 1'b0;
    check("kill_mem_inv", mem_invalid_o, 1);
    check("kill_mem_rd",  mem_rd_o, 0);
    check("kill_retire",  retire_o, 0);
    check("ex_store",     is_store_ex_o, 1);

    // Reset during a redirect
    took_branch_i = 1'b1;
    tick();
    took_branch_i = 1'b0;
    check("rr_busy",     redirect_busy_o, 1);
    reset_i = 1'b1;
    tick();
    check("rr_busy_off", redirect_busy_o, 0);
    check("rr_ex_inv",   ex_invalid_o, 1);
    check("rr_mem_inv",  mem_invalid_o, 1);
    check("rr_wb_inv",   wb_invalid_o, 1);
    check("rr_timeout",  stall_timeout_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
